ysyx_23060332_mem_arb: RTL and testbench
========================================

Name: ysyx_23060332_mem_arb

Overview:
- Arbitrates one shared memory port between the instruction fetch unit (read-only) and the execute stage's load/store path (the block that drives mem_ren/mem_wen today).
- Multi-cycle valid/ready request channel, single-beat response channel, one outstanding transaction at a time.
- Sits between IFU/EXU and the memory/bus bridge.
- Replaces the direct combinational EXU-to-memory connection so loads and stores stall fetch in a controlled way.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MASK_W, 8, write byte-mask width
STARVE_LIM, 4, max consecutive LSU grants while IFU is waiting before IFU is forced to win (>=1)
TIMEOUT, 255, response watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ifu_req_valid  in  1  fetch request
ifu_req_ready  out  1  fetch request accepted this cycle
ifu_addr  in  ADDR_W  fetch address
ifu_rsp_valid  out  1  fetch data valid (1 cycle)
ifu_rdata  out  DATA_W  fetch data
ifu_rsp_err  out  1  fetch error
lsu_req_valid  in  1  load/store request
lsu_req_ready  out  1  load/store accepted
lsu_wen  in  1  1=store, 0=load
lsu_addr  in  ADDR_W  access address
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  MASK_W  store byte mask
lsu_rsp_valid  out  1  load data / store ack (1 cycle)
lsu_rdata  out  DATA_W  load data
lsu_rsp_err  out  1  access error
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_wen  out  1  write enable
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  write data
mem_wmask  out  MASK_W  byte mask
mem_rsp_valid  in  1  memory response
mem_rdata  in  DATA_W  read data
mem_rsp_err  in  1  response error
busy  out  1  state != IDLE
owner  out  1  0=IFU, 1=LSU; valid while busy

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous assert, active low, synchronous deassert at the source.
- Reset state: IDLE. owner=0, starve counter=0, latched request fields=0. Every output is 0 during reset.
- FSM states:
  - IDLE -> REQ on an accept.
  - REQ -> RSP on mem_req_ready=1 with mem_rsp_valid=0.
  - REQ -> IDLE on mem_req_ready=1 and mem_rsp_valid=1 in the same cycle (zero-latency slave; completes in that cycle).
  - RSP -> IDLE on mem_rsp_valid=1.
- Accept (IDLE only):
  - ifu_req_ready / lsu_req_ready are combinational, asserted only in IDLE, and only for the granted requester.
  - Both ready lines are 0 in every other state.
- Arbitration:
  - LSU has fixed priority over IFU.
  - Exception: if starve counter == STARVE_LIM and ifu_req_valid=1, IFU wins.
  - Starve counter increments on each LSU grant while ifu_req_valid=1, saturating at STARVE_LIM.
  - Starve counter clears on any IFU grant, or on an LSU grant with ifu_req_valid=0.
- Latching:
  - On accept, addr/wen/wdata/wmask are registered; IFU requests latch wen=0 and wmask=0.
  - mem_req_valid=1 from the cycle after accept, held until the mem_req_ready handshake.
  - mem_* request fields stay stable while mem_req_valid=1.
- Response:
  - Combinational pass-through: {owner}_rsp_valid = mem_rsp_valid while in RSP, or in REQ when mem_req_ready=1.
  - rdata/err are routed to the owner only; the non-owner sees 0 on its rsp_valid/rdata/err.
  - Each response is exactly one cycle and one response per accepted request.
  - mem_rsp_valid in IDLE, or in REQ without mem_req_ready, is ignored.
- Latency: request accepted at cycle T; mem_req_valid at T+1; earliest response at T+1 (zero-latency slave); next accept earliest at T+2.
- Store acks are returned on lsu_rsp_valid; lsu_rdata is don't-care for stores.
- Reset mid-transaction: immediate return to IDLE. The in-flight transaction is dropped with no response; requesters must reissue.

Optional Feature:
- Macro: YSYX_23060332_MEM_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counter of width clog2(TIMEOUT+1) clears on accept and increments every cycle in REQ/RSP.
  - When it reaches TIMEOUT without completion: owner rsp_valid=1 and rsp_err=1 for one cycle, rdata=0, mem_req_valid drops, FSM -> IDLE.
  - A late mem_rsp_valid after the timeout is ignored.
- Undefined: no counter; the FSM waits indefinitely; rsp_err = mem_rsp_err only.

Test Plan:
- Single fetch: ifu_req_valid=1, addr=0x80000000; memory ready at T+1, response at T+3 with rdata=0x00000413 -> ifu_rsp_valid pulse at T+3, rdata=0x00000413, lsu_rsp_valid=0, busy 1 for T+1..T+3.
- Simultaneous requests: both valid in IDLE -> lsu_req_ready=1, ifu_req_ready=0, owner=1; IFU granted at the next IDLE.
- Starvation: lsu_req_valid and ifu_req_valid held high with STARVE_LIM=4 -> grant order LSU,LSU,LSU,LSU,IFU,LSU...
- Store: lsu_wen=1, addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F -> mem_* fields stable while mem_req_ready=0 for 3 cycles; ack on lsu_rsp_valid.
- Zero-latency slave: mem_req_ready=1 and mem_rsp_valid=1 at T+1 -> response at T+1, IDLE at T+2, new accept at T+2.
- Reset/timeout: rst_n low in RSP -> all outputs 0 asynchronously, no response. With the macro and TIMEOUT=8, memory silent -> rsp_err=1 at accept+9 cycles.

Source files
------------

// File: rtl/ysyx_23060332_mem_arb.sv
`timescale 1ns / 1ps
// ysyx_23060332_mem_arb
//   Shares one memory request/response port between instruction fetch (IFU,
//   read-only) and the load/store path (LSU). One transaction in flight at a
//   time; LSU has priority unless IFU has been passed over STARVE_LIM times.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   ifu_req_* / ifu_rsp_*        fetch request (valid/ready) and 1-cycle response
//   lsu_req_* / lsu_rsp_*        load/store request (valid/ready) and 1-cycle response
//   mem_req_* / mem_rsp_*        downstream memory request and response
//   busy, owner                  transaction in flight; 0=IFU, 1=LSU owns it
//
// Optional feature
//   YSYX_23060332_MEM_ARB_TIMEOUT_EN: response watchdog. After TIMEOUT cycles
//   without completion the owner gets an error response and the arbiter idles.
module ysyx_23060332_mem_arb #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MASK_W     = 8,
    parameter int unsigned STARVE_LIM = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_rsp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_rsp_err,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_rsp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rsp_err,
    output logic              busy,
    output logic              owner
);

    localparam int unsigned SW = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIM);

    typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;

    logic idle, ifu_win, lsu_win, accept, rsp_fire, timeout, rsp_any;

    assign idle    = (state_q == StIdle);
    assign ifu_win = ifu_req_valid && (!lsu_req_valid || (starve_q == StarveMax));
    assign lsu_win = lsu_req_valid && !ifu_win;
    // Ready lines are combinational from the inputs; gate with rst_n so they
    // stay low while reset is held.
    assign ifu_req_ready = rst_n && idle && ifu_win;
    assign lsu_req_ready = rst_n && idle && lsu_win;
    assign accept        = ifu_req_ready || lsu_req_ready;

    // A response counts in RSP, or in REQ when the slave answers in the
    // handshake cycle itself.
    assign rsp_fire = mem_rsp_valid &&
                      ((state_q == StRsp) || ((state_q == StReq) && mem_req_ready));

`ifdef YSYX_23060332_MEM_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WdMax = TW'(TIMEOUT);
    logic [TW-1:0] wd_q, wd_d;

    always_comb begin
        wd_d = wd_q;
        if (accept) begin
            wd_d = '0;
        end else if (!idle) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    // A real completion in the same cycle wins over the watchdog.
    assign timeout = !idle && (wd_q == WdMax) && !rsp_fire;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StReq;
                    owner_d = lsu_req_ready;
                    if (lsu_req_ready) begin
                        addr_d  = lsu_addr;
                        wen_d   = lsu_wen;
                        wdata_d = lsu_wdata;
                        wmask_d = lsu_wmask;
                        // Count only grants that actually passed over a waiting IFU.
                        if (!ifu_req_valid) begin
                            starve_d = '0;
                        end else if (starve_q != StarveMax) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end else begin
                        addr_d   = ifu_addr;
                        wen_d    = 1'b0;
                        wdata_d  = '0;
                        wmask_d  = '0;
                        starve_d = '0;
                    end
                end
            end
            StReq: begin
                if (rsp_fire || timeout) begin
                    state_d = StIdle;
                end else if (mem_req_ready) begin
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (rsp_fire || timeout) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            starve_q <= '0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
        end
    end

    assign rsp_any = rsp_fire || timeout;

    assign ifu_rsp_valid = rsp_any && !owner_q;
    assign ifu_rdata     = (rsp_fire && !owner_q) ? mem_rdata : '0;
    assign ifu_rsp_err   = !owner_q && ((rsp_fire && mem_rsp_err) || timeout);
    assign lsu_rsp_valid = rsp_any && owner_q;
    assign lsu_rdata     = (rsp_fire && owner_q) ? mem_rdata : '0;
    assign lsu_rsp_err   = owner_q && ((rsp_fire && mem_rsp_err) || timeout);

    assign mem_req_valid = (state_q == StReq) && !timeout;
    assign mem_wen       = wen_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    assign busy  = !idle;
    assign owner = owner_q;

endmodule

// File: tb/tb_ysyx_23060332_mem_arb.sv
`timescale 1ns / 1ps
module tb_ysyx_23060332_mem_arb;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ifu_req_valid = 1'b0, ifu_req_ready;
    logic [31:0] ifu_addr = '0;
    logic        ifu_rsp_valid, ifu_rsp_err;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0;
    logic [7:0]  lsu_wmask = '0;
    logic        lsu_rsp_valid, lsu_rsp_err;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid, mem_wen;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid = 1'b0, mem_rsp_err = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy, owner;

    ysyx_23060332_mem_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ifu_req_valid(ifu_req_valid),
        .ifu_req_ready(ifu_req_ready),
        .ifu_addr     (ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rdata    (ifu_rdata),
        .ifu_rsp_err  (ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid),
        .lsu_req_ready(lsu_req_ready),
        .lsu_wen      (lsu_wen),
        .lsu_addr     (lsu_addr),
        .lsu_wdata    (lsu_wdata),
        .lsu_wmask    (lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid),
        .lsu_rdata    (lsu_rdata),
        .lsu_rsp_err  (lsu_rsp_err),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata    (mem_rdata),
        .mem_rsp_err  (mem_rsp_err),
        .busy         (busy),
        .owner        (owner)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Transaction-level reference: is a transaction open, who owns it, has
    // the request been handed to memory yet, and how often IFU was passed over.
    bit          m_busy, m_hs, m_owner;
    int          m_starve;
    logic [31:0] m_addr, m_wdata;
    logic        m_wen;
    logic [7:0]  m_wmask;
    bit          g_ei, g_el, g_fire;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_hs = 0; m_owner = 0; m_starve = 0;
        m_addr = '0; m_wdata = '0; m_wen = 1'b0; m_wmask = '0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ifu_req_ready"}, ifu_req_ready, 0);
        chk({tag, "_lsu_req_ready"}, lsu_req_ready, 0);
        chk({tag, "_ifu_rsp_valid"}, ifu_rsp_valid, 0);
        chk({tag, "_ifu_rdata"}, ifu_rdata, 0);
        chk({tag, "_ifu_rsp_err"}, ifu_rsp_err, 0);
        chk({tag, "_lsu_rsp_valid"}, lsu_rsp_valid, 0);
        chk({tag, "_lsu_rdata"}, lsu_rdata, 0);
        chk({tag, "_lsu_rsp_err"}, lsu_rsp_err, 0);
        chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
        chk({tag, "_mem_wen"}, mem_wen, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_mem_wmask"}, mem_wmask, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_owner"}, owner, 0);
    endtask

    // Called mid-cycle after inputs are driven: compare every output to the model.
    task automatic settle();
        bit ei, el, fire;
        #1;
        ei   = !m_busy && ifu_req_valid && (!lsu_req_valid || m_starve == LIM);
        el   = !m_busy && lsu_req_valid && !ei;
        fire = m_busy && mem_rsp_valid && (m_hs || mem_req_ready);
        chk("ifu_req_ready", ifu_req_ready, ei);
        chk("lsu_req_ready", lsu_req_ready, el);
        chk("mem_req_valid", mem_req_valid, m_busy && !m_hs);
        chk("busy", busy, m_busy);
        chk("owner", owner, m_owner);
        chk("ifu_rsp_valid", ifu_rsp_valid, fire && !m_owner);
        chk("ifu_rdata", ifu_rdata, (fire && !m_owner) ? mem_rdata : 32'h0);
        chk("ifu_rsp_err", ifu_rsp_err, fire && !m_owner && mem_rsp_err);
        chk("lsu_rsp_valid", lsu_rsp_valid, fire && m_owner);
        chk("lsu_rsp_err", lsu_rsp_err, fire && m_owner && mem_rsp_err);
        if (!(fire && m_owner && m_wen))
            chk("lsu_rdata", lsu_rdata, (fire && m_owner) ? mem_rdata : 32'h0);
        if (m_busy && !m_hs) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wen", mem_wen, m_wen);
            chk("mem_wmask", mem_wmask, m_wmask);
            if (m_wen) chk("mem_wdata", mem_wdata, m_wdata);
        end
        g_ei = ei; g_el = el; g_fire = fire;
    endtask

    // Advance one clock and update the model from the inputs that were sampled.
    task automatic tick();
        @(posedge clk);
        if (g_ei || g_el) begin
            m_busy  = 1;
            m_hs    = 0;
            m_owner = g_el;
            if (g_el) begin
                m_addr  = lsu_addr;
                m_wen   = lsu_wen;
                m_wdata = lsu_wdata;
                m_wmask = lsu_wmask;
                if (!ifu_req_valid) m_starve = 0;
                else if (m_starve < LIM) m_starve = m_starve + 1;
            end else begin
                m_addr = ifu_addr; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
                m_starve = 0;
            end
        end else if (m_busy) begin
            if (g_fire) m_busy = 0;
            else if (mem_req_ready) m_hs = 1;
        end
        #1;
    endtask

    int grants[$];
    int exp_grants[6] = '{2, 2, 2, 2, 1, 2};

    initial begin
        model_reset();
        // Reset: everything low even with requests pending.
        #1 rst_n = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #1 check_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        rst_n = 1'b1;
        settle(); tick();

        // Single fetch: accept T, ready T+1, response T+3.
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        settle(); chk("fetch_accept", ifu_req_ready, 1); tick();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        settle(); chk("fetch_addr", mem_addr, 32'h8000_0000); tick();
        mem_req_ready = 1'b0;
        settle(); chk("fetch_busy_t2", busy, 1); tick();
        mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0413;
        settle();
        chk("fetch_rsp", ifu_rsp_valid, 1);
        chk("fetch_rdata", ifu_rdata, 32'h0000_0413);
        chk("fetch_lsu_quiet", lsu_rsp_valid, 0);
        tick();
        mem_rsp_valid = 1'b0;
        settle(); chk("fetch_idle", busy, 0); tick();

        // Simultaneous requests, zero-latency slave.
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_wen = 1'b0;
        lsu_addr = 32'h8000_0200; ifu_addr = 32'h8000_0004;
        settle();
        chk("sim_lsu_ready", lsu_req_ready, 1);
        chk("sim_ifu_ready", ifu_req_ready, 0);
        tick();
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
        mem_rdata = 32'h1234_5678;
        settle();
        chk("sim_owner", owner, 1);
        chk("zl_rsp", lsu_rsp_valid, 1);
        tick();
        settle();
        chk("zl_reaccept", ifu_req_ready, 1);
        chk("zl_idle", busy, 0);
        tick();
        settle(); tick();

        // Starvation: both held high, slave answers at once.
        lsu_req_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            mem_rdata = $urandom;
            settle();
            if (ifu_req_ready) grants.push_back(1);
            if (lsu_req_ready) grants.push_back(2);
            tick();
        end
        chk("starve_count", grants.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < grants.size()) chk($sformatf("starve_grant%0d", i), grants[i], exp_grants[i]);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin settle(); tick(); end
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;

        // Store with a stalling slave; request fields must hold.
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
        settle(); tick();
        lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = $urandom;
        lsu_wdata = $urandom; lsu_wmask = 8'hF0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("st_valid", mem_req_valid, 1);
            chk("st_addr", mem_addr, 32'h8000_1000);
            chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("st_wmask", mem_wmask, 8'h0F);
            chk("st_wen", mem_wen, 1);
            tick();
        end
        mem_req_ready = 1'b1;
        settle(); tick();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1;
        settle();
        chk("st_ack", lsu_rsp_valid, 1);
        chk("st_ifu_quiet", ifu_rsp_valid, 0);
        tick();
        mem_rsp_valid = 1'b0;

        // Reset while waiting in the response phase: no response escapes.
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
        settle(); tick();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        settle(); tick();
        mem_req_ready = 1'b0;
        rst_n = 1'b0; mem_rsp_valid = 1'b1; ifu_req_valid = 1'b1;
        #1 check_zero("midreset");
        model_reset();
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0; ifu_req_valid = 1'b0;
        rst_n = 1'b1;
        settle(); tick();

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            ifu_req_valid = 1'($urandom_range(0, 1));
            ifu_addr      = $urandom;
            lsu_req_valid = 1'($urandom_range(0, 1));
            lsu_wen       = 1'($urandom_range(0, 1));
            lsu_addr      = $urandom;
            lsu_wdata     = $urandom;
            lsu_wmask     = 8'($urandom);
            mem_req_ready = 1'($urandom_range(0, 1));
            mem_rsp_valid = ($urandom_range(0, 2) == 0);
            mem_rsp_err   = ($urandom_range(0, 3) == 0);
            mem_rdata     = $urandom;
            settle(); tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
